// File: rtl/nios_mm_copy_master.sv
// rtl/nios_mm_copy_master.sv - Avalon-MM master that copies or fills a block of 32-bit words
// Registered outputs are computed from the next state and next datapath values.
module nios_mm_copy_master #(
    parameter int ADDR_W       = 16,
    parameter int LEN_W        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic              cmd_fill,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       cmd_fill_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] src_ptr, src_nx, dst_ptr, dst_nx;
    logic [LEN_W-1:0]  len_r, len_nx, wd_nx;
    logic              fill_r, fill_nx;
    logic [31:0]       hold, hold_nx;
    logic [CNT_W-1:0]  lat_cnt, lat_nx;
    logic              wr_last;

    logic              busy_d, done_d, cs_d, rd_d, wr_d;
    logic [3:0]        be_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;

    assign wr_last = (words_done + LEN_W'(1)) == len_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            src_ptr        <= '0;
            dst_ptr        <= '0;
            len_r          <= '0;
            fill_r         <= 1'b0;
            hold           <= '0;
            lat_cnt        <= '0;
            words_done     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_address    <= '0;
            avm_writedata  <= '0;
        end else begin
            state          <= state_nx;
            src_ptr        <= src_nx;
            dst_ptr        <= dst_nx;
            len_r          <= len_nx;
            fill_r         <= fill_nx;
            hold           <= hold_nx;
            lat_cnt        <= lat_nx;
            words_done     <= wd_nx;
            busy           <= busy_d;
            done           <= done_d;
            avm_chipselect <= cs_d;
            avm_read       <= rd_d;
            avm_write      <= wr_d;
            avm_byteenable <= be_d;
            avm_address    <= addr_d;
            avm_writedata  <= wdata_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    if (cmd_len == '0)  state_nx = S_DONE;
                    else if (cmd_fill)  state_nx = S_WR_REQ;
                    else                state_nx = S_RD_REQ;
                end
            end
            S_RD_REQ:  if (!avm_waitrequest) state_nx = S_RD_WAIT;
            S_RD_WAIT: if (lat_cnt <= CNT_W'(1)) state_nx = S_WR_REQ;
            S_WR_REQ: begin
                if (!avm_waitrequest) begin
                    if (wr_last)     state_nx = S_DONE;
                    else if (fill_r) state_nx = S_WR_REQ;
                    else             state_nx = S_RD_REQ;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath next values; pointers only move on an accepted write.
    always_comb begin
        src_nx  = src_ptr;
        dst_nx  = dst_ptr;
        len_nx  = len_r;
        fill_nx = fill_r;
        hold_nx = hold;
        lat_nx  = lat_cnt;
        wd_nx   = words_done;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    src_nx  = cmd_src;
                    dst_nx  = cmd_dst;
                    len_nx  = cmd_len;
                    fill_nx = cmd_fill;
                    hold_nx = cmd_fill_data;
                    wd_nx   = '0;
                end
            end
            S_RD_REQ: if (!avm_waitrequest) lat_nx = CNT_W'(READ_LATENCY);
            S_RD_WAIT: begin
                lat_nx = lat_cnt - CNT_W'(1);
                if (lat_cnt <= CNT_W'(1)) hold_nx = avm_readdata;
            end
            S_WR_REQ: begin
                if (!avm_waitrequest) begin
                    wd_nx  = words_done + LEN_W'(1);
                    dst_nx = dst_ptr + ADDR_W'(1);
                    if (!fill_r) src_nx = src_ptr + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d  = (state_nx == S_RD_REQ) || (state_nx == S_RD_WAIT) || (state_nx == S_WR_REQ);
        done_d  = (state_nx == S_DONE);
        rd_d    = (state_nx == S_RD_REQ);
        wr_d    = (state_nx == S_WR_REQ);
        cs_d    = rd_d || wr_d;
        be_d    = wr_d ? 4'hF : 4'h0;
        addr_d  = rd_d ? src_nx : (wr_d ? dst_nx : '0);
        wdata_d = wr_d ? hold_nx : 32'h0;
    end

endmodule

// File: tb/tb_nios_mm_copy_master.sv
// tb/tb_nios_mm_copy_master.sv - scoreboard bench for nios_mm_copy_master
// Reference model replays each command as a plain word loop over a mirror memory.
module tb_nios_mm_copy_master;

    localparam int AW = 16;
    localparam int LW = 16;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_fill = 1'b0;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [31:0]   cmd_fill_data = '0;
    logic          busy, done;
    logic [LW-1:0] words_done;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect, avm_read, avm_write;
    logic [3:0]    avm_byteenable;
    logic [31:0]   avm_writedata, avm_readdata;
    logic          avm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    nios_mm_copy_master #(.ADDR_W(AW), .LEN_W(LW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_fill(cmd_fill),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill_data(cmd_fill_data),
        .busy(busy), .done(done), .words_done(words_done), .avm_address(avm_address),
        .avm_chipselect(avm_chipselect), .avm_read(avm_read), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic [31:0] rd_pipe [RL];
    assign avm_readdata = rd_pipe[RL-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
        end
    endtask

    // Slave memory with fixed read latency.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
        rd_pipe[0] <= (avm_chipselect && avm_read && !avm_waitrequest) ? mem[avm_address] : 32'h0BAD0BAD;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Waitrequest driver: 0 none, 1 fixed stalls per request, 2 random.
    int stall_mode = 0;
    int stall_n = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!avm_chipselect) begin
            avm_waitrequest = 1'b0;
            stall_cnt = 0;
        end else if (stall_mode == 1) begin
            if (stall_cnt < stall_n) begin
                avm_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end else if (stall_mode == 2) begin
            avm_waitrequest = ($urandom_range(0, 2) == 0);
        end else begin
            avm_waitrequest = 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    typedef struct { int cycles; logic [LW-1:0] len; } done_t;
    wr_t   exp_wr[$];
    done_t exp_done[$];

    int   c0 = 0;
    int   stalls = 0;
    int   done_cnt = 0;
    int   writes_seen = 0;
    logic busy_seen = 1'b0;
    logic cs_seen = 1'b0;
    logic prev_stall = 1'b0;
    logic [55:0] prev_bus;

    // Monitor: samples mid-cycle, pops expectations on accepted writes and done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall)
                check("stall_stable", {avm_address, avm_writedata, avm_chipselect, avm_read, avm_write, avm_byteenable}, prev_bus);
            prev_stall = avm_chipselect && avm_waitrequest;
            prev_bus   = {avm_address, avm_writedata, avm_chipselect, avm_read, avm_write, avm_byteenable};
            if (avm_chipselect && avm_waitrequest) stalls++;
            if (busy) busy_seen = 1'b1;
            if (avm_chipselect) cs_seen = 1'b1;
            if (avm_chipselect && avm_write && !avm_waitrequest) begin
                writes_seen++;
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h required none", avm_address, avm_writedata);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", avm_address, e.a);
                    check("wr_data", avm_writedata, e.d);
                    check("wr_be", avm_byteenable, 4'hF);
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done required none");
                end else begin
                    done_t e;
                    e = exp_done.pop_front();
                    check("done_cycle", cyc - c0, e.cycles + stalls);
                    check("words_done", words_done, e.len);
                    check("busy_at_done", busy, 0);
                    check("writes_left", exp_wr.size(), 0);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic fill, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len, input logic [31:0] fd);
        int    t = 0;
        done_t dn;
        while ((busy || done) && t < 5000) begin
            step(1);
            t++;
        end
        if (len == 0)  dn.cycles = 1;
        else if (fill) dn.cycles = int'(len) + 1;
        else           dn.cycles = (2 + RL) * int'(len) + 1;
        dn.len = len;
        for (int i = 0; i < int'(len); i++) begin
            wr_t w;
            w.a = dst + AW'(i);
            w.d = fill ? fd : ref_mem[src + AW'(i)];
            ref_mem[w.a] = w.d;
            exp_wr.push_back(w);
        end
        exp_done.push_back(dn);
        cmd_fill = fill;
        cmd_src = src;
        cmd_dst = dst;
        cmd_len = len;
        cmd_fill_data = fd;
        cmd_start = 1'b1;
        c0 = cyc;
        stalls = 0;
        step(1);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done();
        int target = done_cnt + 1;
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            step(1);
            t++;
        end
        if (done_cnt < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done required done within 3000 cycles");
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_words"}, words_done, 0);
        check({tag, "_ctrl"}, {avm_chipselect, avm_read, avm_write, avm_byteenable}, 0);
        check({tag, "_addr"}, avm_address, 0);
        check({tag, "_wdata"}, avm_writedata, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = 32'h11111111 * (i + 1);
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];

        step(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        step(2);

        // Copy 4 words 0..3 -> 8..11
        issue(1'b0, 16'h0000, 16'h0008, 16'd4, 32'h0);
        check("copy_busy_c1", busy, 1);
        wait_done();
        for (int i = 0; i < 4; i++) check("copy_mem", mem[8 + i], 32'h11111111 * (i + 1));

        // Fill across the address wrap
        issue(1'b1, 16'h0, 16'hFFFE, 16'd3, 32'hDEADBEEF);
        wait_done();
        check("fill_wrap0", mem[16'hFFFE], 32'hDEADBEEF);
        check("fill_wrap2", mem[16'h0000], 32'hDEADBEEF);

        // Zero length: no bus activity, busy never high
        step(1);
        busy_seen = 1'b0;
        cs_seen = 1'b0;
        issue(1'b0, 16'h0100, 16'h0200, 16'd0, 32'h0);
        check("len0_busy_c1", busy, 0);
        wait_done();
        step(2);
        check("len0_busy_seen", busy_seen, 0);
        check("len0_cs_seen", cs_seen, 0);

        // Two stall cycles on every read and write
        stall_mode = 1;
        stall_n = 2;
        issue(1'b0, 16'h0010, 16'h0020, 16'd2, 32'h0);
        wait_done();
        check("stall_count", stalls, 8);
        stall_mode = 0;

        // cmd_start while busy and during DONE is ignored
        issue(1'b0, 16'h0030, 16'h0040, 16'd5, 32'h0);
        step(3);
        cmd_fill = 1'b1; cmd_dst = 16'h7000; cmd_len = 16'd7; cmd_fill_data = 32'hA5A5A5A5;
        cmd_start = 1'b1;
        step(1);
        cmd_start = 1'b0;
        begin
            int t = 0;
            while (!done && t < 200) begin
                step(1);
                t++;
            end
        end
        check("ign_done_seen", done, 1);
        cmd_start = 1'b1;
        step(1);
        cmd_start = 1'b0;
        writes_seen = 0;
        step(10);
        check("ign_busy_after", busy, 0);
        check("ign_writes_after", writes_seen, 0);
        check("ign_words_hold", words_done, 5);

        // Reset in the middle of a write burst
        issue(1'b1, 16'h0, 16'h0100, 16'd5, 32'h12345678);
        step(1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_wr.delete();
        exp_done.delete();
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        step(2);
        reset_n = 1'b1;
        step(1);
        issue(1'b1, 16'h0, 16'h0300, 16'd1, 32'hCAFEF00D);
        wait_done();
        check("post_reset_fill", mem[16'h0300], 32'hCAFEF00D);

        // Randomized commands with random stalls and overlapping copies
        for (int k = 0; k < 25; k++) begin
            logic [AW-1:0] s, d;
            logic [LW-1:0] l;
            s = AW'($urandom);
            d = ($urandom_range(0, 3) == 0) ? s + AW'($urandom_range(1, 3)) : AW'($urandom);
            l = LW'($urandom_range(0, 10));
            stall_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            issue($urandom_range(0, 2) == 0, s, d, l, $urandom);
            wait_done();
        end
        stall_mode = 0;
        step(3);
        check("final_exp_empty", exp_wr.size() + exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_mm_copy_master.md
# nios_mm_copy_master

Avalon-MM master that copies a block of 32-bit words from one word address range to another, or fills a range with a constant. It is the initiator side for the on-chip memory slaves in the NIOS system, with a fixed slave read latency and `waitrequest` flow control. A simple start/busy/done command port lets control logic preload or clear memory without CPU involvement.

## Interface
Parameters:
- `ADDR_W`, 16: word-address width on the Avalon master.
- `LEN_W`, 16: transfer-length and word-counter width.
- `READ_LATENCY`, 1: cycles from an accepted read until `avm_readdata` is valid. Must be ≥1.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_start` in 1: one-cycle request, sampled only in IDLE.
- `cmd_fill` in 1: 1 = fill mode, 0 = copy mode; latched with `cmd_start`.
- `cmd_src` in ADDR_W: copy source start word address.
- `cmd_dst` in ADDR_W: destination start word address.
- `cmd_len` in LEN_W: number of words to transfer; 0 is legal.
- `cmd_fill_data` in 32: fill pattern, latched with `cmd_start`.
- `busy` out 1: high from the cycle after `cmd_start` is accepted until DONE.
- `done` out 1: one-cycle completion pulse.
- `words_done` out LEN_W: words written so far in the current or last command.
- `avm_address` out ADDR_W: word address.
- `avm_chipselect` out 1
- `avm_read` out 1
- `avm_write` out 1
- `avm_byteenable` out 4: 4'hF during writes, 4'h0 otherwise.
- `avm_writedata` out 32
- `avm_readdata` in 32
- `avm_waitrequest` in 1: stalls the current read or write while high.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- **IDLE:**
  - `cmd_start`=1 latches `src_ptr`, `dst_ptr`, `len`, mode, and fill data, and clears `words_done`.
  - Next state: `cmd_len`=0 → DONE; fill → WR_REQ with hold register = `cmd_fill_data`; copy → RD_REQ.
- **RD_REQ:** `avm_chipselect`=`avm_read`=1, `avm_address`=`src_ptr`. Held stable while `avm_waitrequest`=1. On acceptance (`avm_waitrequest`=0), load a latency counter with READ_LATENCY and go to RD_WAIT.
- **RD_WAIT:** no request asserted. Decrement the counter. When it reaches 1, capture `avm_readdata` into the hold register and go to WR_REQ.
- **WR_REQ:** `avm_chipselect`=`avm_write`=1, `avm_byteenable`=4'hF, `avm_address`=`dst_ptr`, `avm_writedata`=hold register. Held stable while waitrequest is high. On acceptance:
  - `words_done`+1, `dst_ptr`+1, `src_ptr`+1 (copy mode only).
  - If `words_done`+1 == `len` → DONE; otherwise fill → WR_REQ, copy → RD_REQ.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- Pointer arithmetic is modulo 2^ADDR_W; an address of all ones wraps to 0.
- `cmd_len` = 2^LEN_W−1 is the maximum transfer.
- Copy is strictly forward, one word at a time. Overlapping ranges with dst > src replicate the data (no hazard handling).
- `cmd_start` is ignored in every state except IDLE, including DONE.
- Reset (asynchronous, any state) aborts the transfer. All outputs go to 0: `busy`, `done`, `words_done`, all `avm_*` controls, `avm_address`, `avm_writedata`. The FSM returns to IDLE.

## Timing
- Cycle 0 is the cycle in which `cmd_start` is sampled high in IDLE. `busy` rises in cycle 1.
- Outputs are registered. Requests assert at the state entry cycle.
- With zero wait states:
  - Copy: (2+READ_LATENCY) cycles per word, `done` in cycle (2+READ_LATENCY)·N+1. For READ_LATENCY=1 this is 3N+1.
  - Fill: one word per cycle (back-to-back writes), `done` in cycle N+1.
  - `cmd_len`=0: `done` in cycle 1, no bus activity.
- Each waitrequest cycle extends the transfer by exactly one cycle.
- `avm_readdata` is sampled only in the final RD_WAIT cycle.
- `words_done` holds its final value after DONE until the next accepted command.

## Test plan
- Copy, len=4, src=0, dst=8, READ_LATENCY=1, memory words 0..3 = 0x11111111..0x44444444, no waitrequest -> words 8..11 match, `done` in cycle 13, `words_done`=4.
- Fill, len=3, dst=0xFFFE, data=0xDEADBEEF -> writes to 0xFFFE, 0xFFFF, 0x0000; `done` in cycle 4.
- len=0 -> no `avm_chipselect` activity, `done` in cycle 1, `busy` never high.
- Copy, len=2, with `avm_waitrequest` held high 2 cycles on each read and each write -> address and data stable during stalls, `done` in cycle 15.
- `cmd_start` pulsed while busy and during DONE -> ignored; the original transfer completes unchanged.
- `reset_n` low in the middle of a WR_REQ -> all outputs 0 immediately; after release the block is in IDLE and a new fill of len=1 completes in cycle 2.
